mul_array_arbiter: RTL
======================

// Module: mul_array_arbiter
// PURPOSE
//  Shares the single 128-lane 8x8 multiplier array between two layer engines: req 0 = conv, req 1 = fc.
//  Grants the array in bursts with round-robin priority between bursts.
//  Registers the operands into the array and routes each product vector back to the requester that issued it, tagged by a latency pipe.
//  Sits between the layer engines and the multiplier array in the accelerator top level.
// PARAMETERS
//  DATA_W        1024  operand vector width (128 x int8)
//  RES_W         2048  product vector width (128 x int16)
//  MULT_LATENCY  3     multiplier array latency, cycles from mul_data*_o to mul_result_i
//  IDLE_TIMEOUT  16    consecutive owner-idle cycles before a held burst is force-released
// PORTS
//  clk_i              in   1       clock
//  rst_n_i            in   1       async active-low reset
//  r0_req_i/r1_req_i  in   1       beat request (operands valid this cycle)
//  r0_last_i/r1_last_i in  1       beat is last of burst
//  r0_data1_i,r1_data1_i in DATA_W operand A
//  r0_data2_i,r1_data2_i in DATA_W operand B
//  r0_gnt_o/r1_gnt_o  out  1       requester owns array; beat accepted when req&gnt
//  r0_res_valid_o/r1_res_valid_o out 1  product for that requester on res_data_o
//  res_data_o         out  RES_W   registered copy of mul_result_i (shared)
//  mul_data1_o        out  DATA_W  operand A to array
//  mul_data2_o        out  DATA_W  operand B to array
//  mul_result_i       in   RES_W   array products
//  busy_o             out  1       state!=IDLE or any beat in flight
//  perf_busy_cnt_o    out  32      perf: cycles with an accepted beat
//  perf_stall_cnt_o   out  32      perf: cycles a non-owner requested
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; rr pointer = 0 (req 0 favoured); tag pipe cleared.
//    Reset mid-operation discards in-flight beats; no res_valid follows.
//  - FSM IDLE/OWN0/OWN1, grants registered: r0_gnt_o = (state==OWN0), r1_gnt_o = (state==OWN1).
//  - IDLE: if any req, go to OWNk next cycle. Both requesting: pick rr pointer. One cycle grant latency.
//  - OWNk, accepted beat with last=1: release.
//    Next state = OWN(other) if other req, else OWNk if own req, else IDLE; rr pointer <= other.
//  - OWNk, req_k low: idle counter increments. On reaching IDLE_TIMEOUT, release as for last.
//    Counter clears on every accepted beat and on state change.
//  - Non-owner req is ignored (no grant, no accept); requester must hold operands until granted.
//  - Beat accepted at cycle T: mul_data*_o <= owner operands at T+1. Non-accept cycles drive 0 (power).
//  - Tag pipe, depth MULT_LATENCY+1, carries {valid,owner}.
//    rk_res_valid_o and res_data_o are registered at T+2+MULT_LATENCY (=T+5 default), one cycle pulse per beat.
//  - Back-to-back beats: 1 per cycle, no bubbles inside a burst; burst-to-burst handover: 0 bubble cycles.
//  - res_data_o updates every cycle; meaningful only with a valid pulse. Widths unchanged, no truncation.
//  - busy_o = (state!=IDLE) | (|tag_valid).
// CONFIGURATION
//  - MUL_ARB_PERF_EN defined: perf_busy_cnt_o and perf_stall_cnt_o count, saturating at 32'hFFFF_FFFF.
//    They clear only on reset.
//  - MUL_ARB_PERF_EN undefined: both perf ports tied to 32'd0, no counter flops.
// TESTING
//  1. r0 single 4-beat burst (last on beat 4) -> r0_gnt_o 1 cycle after req.
//     4 r0_res_valid_o pulses, each at accept+5; res_data_o equals model products.
//  2. r0,r1 request together from reset -> r0 owns first.
//     After r0 last beat, r1_gnt_o rises next cycle with no gap; then rr favours r0.
//  3. r1 owns, drops req for 16 cycles -> forced release to IDLE or to waiting r0.
//     No spurious res_valid; busy_o falls once pipe drains.
//  4. rst_n_i asserted with 3 beats in flight -> all outputs 0 immediately; no res_valid after release.
//  5. fc-style stream of 512 beats from r1 (128 channels x 4 groups) while r0 idles.
//     512 pulses in order; mul_data*_o 0 outside accepted cycles.
//  6. With MUL_ARB_PERF_EN, test 2 traffic -> perf_busy_cnt_o = total beats.
//     perf_stall_cnt_o = r1 waiting cycles; without macro both 0.

Source files
------------

// File: rtl/mul_array_arbiter.sv
// Shares one 128-lane 8x8 multiplier array between two layer engines (req 0 = conv, req 1 = fc).
// Latency: grant 1 cycle after request from IDLE; product valid pulse at accept+2+MULT_LATENCY.
// Backpressure: only the burst owner is accepted; non-owners hold operands until granted.
// Ports: clk_i/rst_n_i; rK_req_i/rK_last_i/rK_data1_i/rK_data2_i in, rK_gnt_o/rK_res_valid_o out;
//        res_data_o, mul_data1_o/mul_data2_o to the array, mul_result_i from it; busy_o; perf counters.
// Optional: define MUL_ARB_PERF_EN to enable the saturating perf counters (otherwise tied to 0).
module mul_array_arbiter #(
  parameter int DATA_W       = 1024,
  parameter int RES_W        = 2048,
  parameter int MULT_LATENCY = 3,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              r0_req_i,
  input  logic              r0_last_i,
  input  logic [DATA_W-1:0] r0_data1_i,
  input  logic [DATA_W-1:0] r0_data2_i,
  input  logic              r1_req_i,
  input  logic              r1_last_i,
  input  logic [DATA_W-1:0] r1_data1_i,
  input  logic [DATA_W-1:0] r1_data2_i,
  output logic              r0_gnt_o,
  output logic              r1_gnt_o,
  output logic              r0_res_valid_o,
  output logic              r1_res_valid_o,
  output logic [RES_W-1:0]  res_data_o,
  output logic [DATA_W-1:0] mul_data1_o,
  output logic [DATA_W-1:0] mul_data2_o,
  input  logic [RES_W-1:0]  mul_result_i,
  output logic              busy_o,
  output logic [31:0]       perf_busy_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
);

  localparam int TAG_D = MULT_LATENCY + 1;
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t             state, state_nxt;
  logic               rr, rr_nxt;          // 0: req 0 favoured on a tie from IDLE
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic [TAG_D-1:0]   tag_vld;
  logic [TAG_D-1:0]   tag_own;

  logic own_req, oth_req, own_last, owning, accept, timeout, rel;

  assign owning   = (state == S_OWN0) || (state == S_OWN1);
  assign own_req  = (state == S_OWN1) ? r1_req_i  : r0_req_i;
  assign oth_req  = (state == S_OWN1) ? r0_req_i  : r1_req_i;
  assign own_last = (state == S_OWN1) ? r1_last_i : r0_last_i;
  assign accept   = owning && own_req;
  assign timeout  = owning && !own_req && (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));
  // A last-beat release re-arms the same owner if it is still requesting and the
  // other side is not; the idle timeout is what eventually returns the array to IDLE.
  assign rel      = (accept && own_last) || timeout;

  assign r0_gnt_o = (state == S_OWN0);
  assign r1_gnt_o = (state == S_OWN1);
  assign busy_o   = (state != S_IDLE) || (|tag_vld);

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr;
    idle_cnt_nxt = idle_cnt;
    case (state)
      S_IDLE: begin
        idle_cnt_nxt = '0;
        if (r0_req_i && r1_req_i) state_nxt = rr ? S_OWN1 : S_OWN0;
        else if (r0_req_i)        state_nxt = S_OWN0;
        else if (r1_req_i)        state_nxt = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (rel) begin
          idle_cnt_nxt = '0;
          rr_nxt       = (state == S_OWN0);
          if (oth_req)      state_nxt = (state == S_OWN0) ? S_OWN1 : S_OWN0;
          else if (own_req) state_nxt = state;
          else              state_nxt = S_IDLE;
        end else if (accept) begin
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      rr       <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr       <= rr_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Operand register: zero when nothing is accepted so the array does not toggle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mul_data1_o <= '0;
      mul_data2_o <= '0;
    end else if (accept) begin
      mul_data1_o <= (state == S_OWN1) ? r1_data1_i : r0_data1_i;
      mul_data2_o <= (state == S_OWN1) ? r1_data2_i : r0_data2_i;
    end else begin
      mul_data1_o <= '0;
      mul_data2_o <= '0;
    end
  end

  // Tag pipe tracks each beat through the operand register and the array latency;
  // its last stage lines up with mul_result_i, which is then registered with the tag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_vld        <= '0;
      tag_own        <= '0;
      r0_res_valid_o <= 1'b0;
      r1_res_valid_o <= 1'b0;
      res_data_o     <= '0;
    end else begin
      tag_vld[0] <= accept;
      tag_own[0] <= (state == S_OWN1);
      for (int i = 1; i < TAG_D; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
      r0_res_valid_o <= tag_vld[TAG_D-1] && !tag_own[TAG_D-1];
      r1_res_valid_o <= tag_vld[TAG_D-1] &&  tag_own[TAG_D-1];
      res_data_o     <= mul_result_i;
    end
  end

`ifdef MUL_ARB_PERF_EN
  logic stall;
  assign stall = (r0_req_i && !r0_gnt_o) || (r1_req_i && !r1_gnt_o);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_busy_cnt_o  <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (accept && (perf_busy_cnt_o != 32'hFFFF_FFFF))
        perf_busy_cnt_o <= perf_busy_cnt_o + 32'd1;
      if (stall && (perf_stall_cnt_o != 32'hFFFF_FFFF))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`else
  assign perf_busy_cnt_o  = 32'd0;
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule
